// File: rtl/mul_issue_if.sv
// Bundle of request, multiplier-issue and response signals for mul_issue.
// slave  : view seen by mul_issue itself.
// master : view seen by whatever surrounds it (requester, multiplier, consumer).
interface mul_issue_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;

  logic             mul_in_valid;
  logic             mul_in_ready;
  logic [32:0]      mul_src1;
  logic [32:0]      mul_src2;
  logic             mul_out_valid;
  logic [63:0]      mul_result;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, flush,
    input  mul_in_ready, mul_out_valid, mul_result, resp_ready,
    output req_ready, mul_in_valid, mul_src1, mul_src2,
    output resp_valid, resp_data, resp_tag
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, flush,
    output mul_in_ready, mul_out_valid, mul_result, resp_ready,
    input  req_ready, mul_in_valid, mul_src1, mul_src2,
    input  resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/mul_issue.sv
// Single-outstanding issue stage for the RV32M multiply instructions.
// Extends operands for a 33x33 signed Booth multiplier, waits for its
// done pulse, selects the low or high product word and returns it with
// the request tag. flush aborts the in-flight operation; a multiplier
// result already in flight is swallowed in DRAIN.
module mul_issue #(
  parameter int unsigned TAG_W = 4
) (
  input  logic      clk,
  input  logic      reset,
  mul_issue_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [32:0]      src1_q, src1_d;
  logic [32:0]      src2_q, src2_d;
  logic [31:0]      data_q, data_d;
  logic             accept;
  op_e              req_op;

  // Next-state, capture and handshake decode
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    data_d  = data_q;
    req_op  = op_e'(bus.req_op);
    accept  = bus.req_valid && !bus.flush && (state_q == S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          tag_d   = bus.req_tag;
          src1_d  = {bus.req_a[31] & ((req_op == OP_MULH) || (req_op == OP_MULHSU)), bus.req_a};
          src2_d  = {bus.req_b[31] & (req_op == OP_MULH), bus.req_b};
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A handshake in the same cycle as flush means the multiplier owns
        // the operation, so its result must still be drained.
        if (bus.mul_in_ready) begin
          state_d = bus.flush ? S_DRAIN : S_WAIT;
        end else if (bus.flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A result coinciding with flush is the pulse DRAIN would discard,
        // so go straight to IDLE instead of waiting for one that never comes.
        if (bus.flush) begin
          state_d = bus.mul_out_valid ? S_IDLE : S_DRAIN;
        end else if (bus.mul_out_valid) begin
          data_d  = (op_q == OP_MUL) ? bus.mul_result[31:0] : bus.mul_result[63:32];
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.flush || bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.mul_out_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand/result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      tag_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      data_q  <= data_d;
    end
  end

  // Outputs; req_ready also gated by reset so it stays low while held in reset
  always_comb begin
    bus.req_ready    = reset && !bus.flush && (state_q == S_IDLE);
    bus.mul_in_valid = (state_q == S_ISSUE);
    bus.mul_src1     = src1_q;
    bus.mul_src2     = src2_q;
    bus.resp_valid   = (state_q == S_RESP);
    bus.resp_data    = data_q;
    bus.resp_tag     = tag_q;
  end

endmodule

// File: tb/tb_mul_issue.sv
// Self-checking bench for mul_issue. The multiplier is modelled by the bench
// as a 33x33 signed product; expected responses come from the ISA meaning
// of MUL/MULH/MULHSU/MULHU computed with 64-bit arithmetic.
module tb_mul_issue;
  localparam int unsigned TAG_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned checks = 0;
  int unsigned errors = 0;

  mul_issue_if #(.TAG_W(TAG_W)) bus ();

  mul_issue #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_src1(input logic [1:0] op, input logic [31:0] a);
    return {a[31] & ((op == 2'b01) || (op == 2'b10)), a};
  endfunction

  function automatic logic [32:0] ref_src2(input logic [1:0] op, input logic [31:0] b);
    return {b[31] & (op == 2'b01), b};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      2'b00:   begin p = 64'(sa * sb); return p[31:0];  end
      2'b01:   begin p = 64'(sa * sb); return p[63:32]; end
      2'b10:   begin p = 64'(sa * ub); return p[63:32]; end
      default: begin p = 64'(ua * ub); return p[63:32]; end
    endcase
  endfunction

  function automatic logic [63:0] mul_model(input logic [32:0] s1, input logic [32:0] s2);
    logic signed [65:0] e1, e2, p;
    e1 = {{33{s1[32]}}, s1};
    e2 = {{33{s2[32]}}, s2};
    p  = e1 * e2;
    return p[63:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic issue_now();
    bus.mul_in_ready = 1'b1;
    cyc();
    bus.mul_in_ready = 1'b0;
  endtask

  task automatic pulse(input logic [63:0] res);
    bus.mul_out_valid = 1'b1;
    bus.mul_result    = res;
    cyc();
    bus.mul_out_valid = 1'b0;
    bus.mul_result    = {$urandom, $urandom};
  endtask

  // One full transaction with cycle-accurate checks at every stage
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int unsigned rdy_dly,
                       input int unsigned lat, input int unsigned rsp_dly, output logic [31:0] got);
    logic [32:0] e1, e2;
    logic [31:0] exp_d;
    e1    = ref_src1(op, a);
    e2    = ref_src2(op, b);
    exp_d = ref_result(op, a, b);
    got   = 'x;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: req_ready=%b expected 1", bus.req_ready);
    end
    cyc();
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_op    = 2'($urandom);
    for (int unsigned k = 0; k <= rdy_dly; k++) begin
      bus.mul_in_ready = (k == rdy_dly);
      #1;
      checks++;
      if (bus.mul_in_valid !== 1'b1 || bus.mul_src1 !== e1 || bus.mul_src2 !== e2 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL issue: in_valid=%b src1=%h src2=%h req_ready=%b expected 1 %h %h 0",
                 bus.mul_in_valid, bus.mul_src1, bus.mul_src2, bus.req_ready, e1, e2);
      end
      cyc();
    end
    bus.mul_in_ready = 1'b0;
    for (int unsigned j = 0; j < lat; j++) begin
      #1;
      checks++;
      if (bus.mul_in_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait: in_valid=%b resp_valid=%b req_ready=%b expected 0 0 0",
                 bus.mul_in_valid, bus.resp_valid, bus.req_ready);
      end
      cyc();
    end
    pulse(mul_model(e1, e2));
    for (int unsigned k = 0; k <= rsp_dly; k++) begin
      bus.resp_ready = (k == rsp_dly);
      #1;
      if (k == 0) got = bus.resp_data;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_d || bus.resp_tag !== tag || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp: valid=%b data=%h tag=%h req_ready=%b expected 1 %h %h 0",
                 bus.resp_valid, bus.resp_data, bus.resp_tag, bus.req_ready, exp_d, tag);
      end
      cyc();
    end
    bus.resp_ready = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_done: resp_valid=%b req_ready=%b expected 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mul_in_valid !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_data !== 32'h0 || bus.resp_tag !== '0 || bus.mul_src1 !== 33'h0 || bus.mul_src2 !== 33'h0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b inv=%b rv=%b data=%h tag=%h s1=%h s2=%h expected all zero",
               bus.req_ready, bus.mul_in_valid, bus.resp_valid, bus.resp_data, bus.resp_tag, bus.mul_src1, bus.mul_src2);
    end
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b expected 1", bus.req_ready);
    end
    cyc();
  endtask

  task automatic test_directed();
    logic [31:0] got;
    do_op(2'b00, 32'h3, 32'hFFFF_FFFE, 4'd5, 0, 2, 0, got);
    checks++;
    if (got !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL dir_mul: resp_data=%h expected fffffffa", got);
    end
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 4'd1, 1, 0, 0, got);
    checks++;
    if (got !== 32'h4000_0000) begin
      errors++;
      $display("FAIL dir_mulh: resp_data=%h expected 40000000", got);
    end
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 0, 1, 1, got);
    checks++;
    if (got !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL dir_mulhsu: resp_data=%h expected ffffffff", got);
    end
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14, 2, 3, 0, got);
    checks++;
    if (got !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL dir_mulhu: resp_data=%h expected fffffffe", got);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got;
    do_op(2'b11, $urandom, $urandom, 4'd7, 0, 1, 5, got);
  endtask

  task automatic test_flush_idle();
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block: req_ready=%b expected 0", bus.req_ready);
    end
    cyc();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.mul_in_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_noaccept: in_valid=%b req_ready=%b expected 0 1", bus.mul_in_valid, bus.req_ready);
    end
    cyc();
  endtask

  task automatic test_flush_issue();
    accept(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 4'd3);
    bus.flush        = 1'b1;
    bus.mul_in_ready = 1'b0;
    #1;
    checks++;
    if (bus.mul_in_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_issue_pre: mul_in_valid=%b expected 1", bus.mul_in_valid);
    end
    cyc();
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.mul_in_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_issue_idle: in_valid=%b req_ready=%b expected 0 1", bus.mul_in_valid, bus.req_ready);
    end
    cyc();
    accept(2'b00, 32'h5, 32'h6, 4'd4);
    bus.flush        = 1'b1;
    bus.mul_in_ready = 1'b1;
    cyc();
    bus.flush        = 1'b0;
    bus.mul_in_ready = 1'b0;
    #1;
    checks++;
    if (bus.mul_in_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_issue_drain: in_valid=%b req_ready=%b expected 0 0", bus.mul_in_valid, bus.req_ready);
    end
    cyc();
    pulse(64'h1E);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_issue_drained: resp_valid=%b req_ready=%b expected 0 1", bus.resp_valid, bus.req_ready);
    end
    cyc();
  endtask

  task automatic test_flush_wait();
    accept(2'b00, 32'd7, 32'd6, 4'd2);
    issue_now();
    cyc();
    cyc();
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_ready: req_ready=%b expected 0", bus.req_ready);
    end
    cyc();
    bus.flush = 1'b0;
    for (int unsigned j = 0; j < 2; j++) begin
      #1;
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.mul_in_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_wait_drain: resp_valid=%b req_ready=%b in_valid=%b expected 0 0 0",
                 bus.resp_valid, bus.req_ready, bus.mul_in_valid);
      end
      cyc();
    end
    pulse(64'd42);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_wait_after: resp_valid=%b req_ready=%b expected 0 1", bus.resp_valid, bus.req_ready);
    end
    cyc();
  endtask

  task automatic test_flush_resp();
    accept(2'b00, 32'd9, 32'd9, 4'd11);
    issue_now();
    pulse(64'd81);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd81) begin
      errors++;
      $display("FAIL flush_resp_pre: resp_valid=%b data=%h expected 1 00000051", bus.resp_valid, bus.resp_data);
    end
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_resp_drop: resp_valid=%b req_ready=%b expected 0 1", bus.resp_valid, bus.req_ready);
    end
    cyc();
  endtask

  task automatic test_spurious_pulse();
    logic [31:0] got;
    pulse(64'hDEAD_BEEF_CAFE_F00D);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL spurious_idle: resp_valid=%b req_ready=%b expected 0 1", bus.resp_valid, bus.req_ready);
    end
    cyc();
    do_op(2'b00, 32'd100, 32'd3, 4'd6, 0, 0, 0, got);
    checks++;
    if (got !== 32'd300) begin
      errors++;
      $display("FAIL spurious_followup: resp_data=%h expected 0000012c", got);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    accept(2'b01, 32'hF000_0001, 32'h8000_0003, 4'd13);
    issue_now();
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mul_in_valid !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_data !== 32'h0 || bus.resp_tag !== '0 || bus.mul_src1 !== 33'h0 || bus.mul_src2 !== 33'h0) begin
      errors++;
      $display("FAIL reset_mid_values: rdy=%b inv=%b rv=%b data=%h tag=%h s1=%h s2=%h expected all zero",
               bus.req_ready, bus.mul_in_valid, bus.resp_valid, bus.resp_data, bus.resp_tag, bus.mul_src1, bus.mul_src2);
    end
    cyc();
    cyc();
    bus.mul_in_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mul_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: req_ready=%b resp_valid=%b in_valid=%b expected 1 0 0",
               bus.req_ready, bus.resp_valid, bus.mul_in_valid);
    end
    cyc();
    do_op(2'b10, 32'h8000_0000, 32'h0000_0002, 4'd8, 1, 1, 0, got);
    checks++;
    if (got !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mid_fresh: resp_data=%h expected ffffffff", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, a, b;
    logic [1:0]  op;
    for (int unsigned i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) b = 32'hFFFF_FFFF;
      do_op(op, a, b, TAG_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 2), got);
      if ($urandom_range(0, 1) == 1) cyc();
    end
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_op        = 2'b00;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.req_tag       = '0;
    bus.flush         = 1'b0;
    bus.mul_in_ready  = 1'b0;
    bus.mul_out_valid = 1'b0;
    bus.mul_result    = '0;
    bus.resp_ready    = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush_idle();
    test_flush_issue();
    test_flush_wait();
    test_flush_resp();
    test_spurious_pulse();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
